// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 16-bit ALU between NUM_REQ requesters.
// Optional perf counters (perf_grants, perf_stall) are enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]    req_op,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  output logic [2:0]              alu_ctrl,
  input  logic [15:0]             alu_result,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [15:0]             rsp_result,
  output logic                    rsp_zero,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]             perf_grants,
  output logic [15:0]             perf_stall,
`endif
  input  logic                    rsp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, id_q;
  logic [15:0]    a_q, b_q, res_q;
  logic [2:0]     op_q;
  logic           zero_q;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           accept;

  // First valid requester searching upward from the one after the last grant
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated with rst so nothing is accepted while reset is asserted
  always_comb begin
    accept    = (state_q == IDLE) && gnt_found && !rst;
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDW'(NUM_REQ - 1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= gnt_idx;
        id_q   <= gnt_idx;
        a_q    <= req_a[16*gnt_idx +: 16];
        b_q    <= req_b[16*gnt_idx +: 16];
        op_q   <= req_op[3*gnt_idx +: 3];
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] grants_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept && grants_q != 16'hFFFF) grants_q <= grants_q + 16'd1;
      if (state_q == RESP && !rsp_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_grants = grants_q;
  assign perf_stall  = stall_q;
`endif

endmodule
